// File: rtl/ram_serializer_pkg.sv
// Shared definitions for the RAM store serializer: size codes, FSM states
// and the size-code to last-lane-index conversion.
package ram_serializer_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Index of the final lane of a request: bytes requested, clamped to the
  // word width, minus one.
  function automatic logic [2:0] sizeToLast(input logic [1:0] size, input int wordBytes);
    int n;
    case (size)
      SZ_B:    n = 1;
      SZ_H:    n = 2;
      SZ_W:    n = 4;
      SZ_D:    n = 8;
      default: n = 8;
    endcase
    if (n > wordBytes) n = wordBytes;
    return 3'(n - 1);
  endfunction

endpackage

// File: rtl/ram_serializer_lane_mux.sv
// Combinational lane select: picks one lane of a latched word for the current
// beat index, honouring the byte order. Shared with the future load path.
module ram_lane_mux
  import ram_serializer_pkg::*;
#(
  parameter int WORD_BYTES = 8,
  parameter int LANE_W     = 8,
  parameter int BIG_ENDIAN = 0
) (
  input  logic [WORD_BYTES*LANE_W-1:0] data_i,
  input  logic [2:0]                   idx_i,
  input  logic [2:0]                   last_i,
  output logic [LANE_W-1:0]            q_o
);

  logic [2:0] lane;

  // Map beat index to a lane and select it; unused lane codes read as zero.
  always_comb begin
    lane = (BIG_ENDIAN != 0) ? (last_i - idx_i) : idx_i;
    q_o  = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (lane == 3'(i)) q_o = data_i[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/ram_serializer.sv
// Byte-serial RAM store path: latches one store request and emits its
// selected lanes as single-lane write beats with backpressure, stalling the
// CPU until the final beat is accepted.
module ram_serializer
  import ram_serializer_pkg::*;
#(
  parameter int WORD_BYTES = 8,
  parameter int LANE_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   size,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [WORD_BYTES*LANE_W-1:0] d,
  input  logic                         mem_ready,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            adq,
  output logic [LANE_W-1:0]            q,
  output logic                         kp,
  output logic                         done
);

  localparam int DataW = WORD_BYTES * LANE_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DataW-1:0]  data_q, data_d;
  logic [2:0]        last_q, last_d;
  logic [2:0]        idx_q, idx_d;
  logic [LANE_W-1:0] laneData;
  logic              isLast;

  ram_lane_mux #(
    .WORD_BYTES(WORD_BYTES),
    .LANE_W    (LANE_W),
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane_mux (
    .data_i(data_q),
    .idx_i (idx_q),
    .last_i(last_q),
    .q_o   (laneData)
  );

  assign isLast = (idx_q == last_q);

  // Next-state and beat outputs; reset forces every output low and drops the request.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    data_d  = data_q;
    last_d  = last_q;
    idx_d   = idx_q;
    mem_we  = 1'b0;
    kp      = 1'b0;
    done    = 1'b0;
    adq     = '0;
    q       = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_d  = addr;
            data_d  = d;
            last_d  = sizeToLast(size, WORD_BYTES);
            idx_d   = 3'd0;
            kp      = 1'b1;
            state_d = ST_XFER;
          end
        end
        ST_XFER: begin
          mem_we = 1'b1;
          adq    = base_q + ADDR_W'(idx_q);
          q      = laneData;
          kp     = ~(isLast & mem_ready);
          if (mem_ready) begin
            if (isLast) begin
              done    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, request and beat-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      data_q  <= '0;
      last_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      data_q  <= data_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

endmodule
